// File: rtl/memoredf_pkg.sv
// Shared constants and types for the per-core packet path (dispatcher -> queue_bank -> EDF scheduler).
package memoredf_pkg;

    localparam int unsigned PACKET_WIDTH = 8;
    localparam int unsigned NB_QUEUES    = 4;
    localparam int unsigned QUEUE_DEPTH  = 8;

    typedef logic [PACKET_WIDTH-1:0]      packet_t;
    typedef logic [$clog2(NB_QUEUES)-1:0] queue_id_t;

    // Bits needed to count 0..depth inclusive.
    function automatic int unsigned occ_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/packet_fifo.sv
// Single first-word-fall-through packet queue with drop-on-full and overflow pulse.
// Optional saturating drop counter when QUEUE_BANK_DROP_COUNT_EN is defined.
module packet_fifo
    import memoredf_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          push,
    input  logic [WIDTH-1:0]              din,
    input  logic                          pop,
    output logic [WIDTH-1:0]              head,
    output logic                          empty,
    output logic                          full,
    output logic                          overflow,
`ifdef QUEUE_BANK_DROP_COUNT_EN
    output logic [15:0]                   dropcount,
`endif
    output logic [occ_width(DEPTH)-1:0]   occupancy
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned OW = occ_width(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [OW-1:0]    occ;
    logic [OW-1:0]    occ_next;
    logic             do_push;
    logic             do_pop;
    logic             drop;

    assign empty     = (occ == '0);
    assign full      = (occ == OW'(DEPTH));
    assign occupancy = occ;
    assign head      = empty ? '0 : mem[rptr];

    // A pop on a full queue frees the slot the simultaneous push needs.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign drop    = push && !do_push;

    always_comb begin
        occ_next = occ;
        case ({do_push, do_pop})
            2'b10:   occ_next = occ + 1'b1;
            2'b01:   occ_next = occ - 1'b1;
            default: occ_next = occ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (do_push && !reset) begin
            mem[wptr] <= din;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wptr     <= '0;
            rptr     <= '0;
            occ      <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            occ      <= occ_next;
            overflow <= drop;
        end
    end

`ifdef QUEUE_BANK_DROP_COUNT_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            dropcount <= '0;
        end else if (drop && (dropcount != '1)) begin
            dropcount <= dropcount + 1'b1;
        end
    end
`endif

endmodule

// File: rtl/queue_bank.sv
// Bank of NB_QUEUES independent FWFT packet queues fed by the dispatcher lanes.
// Define QUEUE_BANK_DROP_COUNT_EN to add per-queue saturating dropCount outputs.
module queue_bank
    import memoredf_pkg::*;
#(
    parameter int unsigned PACKET_WIDTH = memoredf_pkg::PACKET_WIDTH,
    parameter int unsigned NB_QUEUES    = memoredf_pkg::NB_QUEUES,
    parameter int unsigned QUEUE_DEPTH  = memoredf_pkg::QUEUE_DEPTH
) (
    input  logic                                            clock,
    input  logic                                            reset,
    input  logic [NB_QUEUES*PACKET_WIDTH-1:0]               packetsIn,
    input  logic [NB_QUEUES-1:0]                            produced,
    input  logic [NB_QUEUES-1:0]                            consume,
    output logic [NB_QUEUES*PACKET_WIDTH-1:0]               heads,
    output logic [NB_QUEUES-1:0]                            empty,
    output logic [NB_QUEUES-1:0]                            full,
    output logic [NB_QUEUES-1:0]                            overflow,
`ifdef QUEUE_BANK_DROP_COUNT_EN
    output logic [NB_QUEUES*16-1:0]                         dropCount,
`endif
    output logic [NB_QUEUES*occ_width(QUEUE_DEPTH)-1:0]     occupancy
);

    localparam int unsigned OW = occ_width(QUEUE_DEPTH);

    for (genvar i = 0; i < NB_QUEUES; i++) begin : g_queue
        packet_fifo #(
            .WIDTH (PACKET_WIDTH),
            .DEPTH (QUEUE_DEPTH)
        ) u_fifo (
            .clock     (clock),
            .reset     (reset),
            .push      (produced[i]),
            .din       (packetsIn[i*PACKET_WIDTH +: PACKET_WIDTH]),
            .pop       (consume[i]),
            .head      (heads[i*PACKET_WIDTH +: PACKET_WIDTH]),
            .empty     (empty[i]),
            .full      (full[i]),
            .overflow  (overflow[i]),
`ifdef QUEUE_BANK_DROP_COUNT_EN
            .dropcount (dropCount[i*16 +: 16]),
`endif
            .occupancy (occupancy[i*OW +: OW])
        );
    end

endmodule

// File: tb/tb_queue_bank.sv
// Directed self-checking bench for queue_bank (default 8-bit x 4 queues x depth 8).
module tb_queue_bank;

    localparam int unsigned PW = 8;
    localparam int unsigned NQ = 4;
    localparam int unsigned OW = 4;

    logic              clock = 1'b0;
    logic              reset;
    logic [NQ*PW-1:0]  packetsIn;
    logic [NQ-1:0]     produced;
    logic [NQ-1:0]     consume;
    logic [NQ*PW-1:0]  heads;
    logic [NQ-1:0]     empty;
    logic [NQ-1:0]     full;
    logic [NQ-1:0]     overflow;
    logic [NQ*OW-1:0]  occupancy;
`ifdef QUEUE_BANK_DROP_COUNT_EN
    logic [NQ*16-1:0]  dropCount;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    queue_bank #(
        .PACKET_WIDTH (PW),
        .NB_QUEUES    (NQ),
        .QUEUE_DEPTH  (8)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .packetsIn (packetsIn),
        .produced  (produced),
        .consume   (consume),
        .heads     (heads),
        .empty     (empty),
        .full      (full),
        .overflow  (overflow),
`ifdef QUEUE_BANK_DROP_COUNT_EN
        .dropCount (dropCount),
`endif
        .occupancy (occupancy)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [PW-1:0] head_of(input int q);
        return heads[q*PW +: PW];
    endfunction

    function automatic logic [OW-1:0] occ_of(input int q);
        return occupancy[q*OW +: OW];
    endfunction

    task automatic push_q(input int q, input logic [PW-1:0] v);
        produced          = '0;
        produced[q]       = 1'b1;
        packetsIn[q*PW +: PW] = v;
        step();
        produced          = '0;
    endtask

    task automatic pop_q(input int q);
        consume    = '0;
        consume[q] = 1'b1;
        step();
        consume    = '0;
    endtask

    logic [PW-1:0] exp3 [8];

    initial begin
        reset     = 1'b1;
        produced  = '1;
        consume   = '0;
        packetsIn = 32'hA5A5_A5A5;
        step();
        reset    = 1'b0;
        produced = '0;
        check("rst_empty", 64'(empty), 64'hF);
        check("rst_full", 64'(full), 64'h0);
        check("rst_heads", 64'(heads), 64'h0);
        check("rst_occ", 64'(occupancy), 64'h0);
        check("rst_ovf", 64'(overflow), 64'h0);

        // single push on queue 0
        push_q(0, 8'd42);
        check("push_head0", 64'(head_of(0)), 64'd42);
        check("push_empty", 64'(empty), 64'hE);
        check("push_occ", 64'(occupancy), 64'h0001);
        check("push_heads_other", 64'(heads[31:8]), 64'h0);

        // fill queue 2, then overflow
        for (int k = 1; k <= 8; k++) begin
            push_q(2, PW'(k));
            check("fill2_ovf", 64'(overflow), 64'h0);
        end
        check("fill2_full", 64'(full), 64'h4);
        check("fill2_occ", 64'(occ_of(2)), 64'd8);
        check("fill2_head", 64'(head_of(2)), 64'd1);
        push_q(2, 8'd99);
        check("ovf2_pulse", 64'(overflow), 64'h4);
        check("ovf2_occ", 64'(occ_of(2)), 64'd8);
        step();
        check("ovf2_clear", 64'(overflow), 64'h0);
        for (int k = 1; k <= 8; k++) begin
            check("drain2_head", 64'(head_of(2)), 64'(k));
            pop_q(2);
        end
        check("drain2_empty", 64'(empty[2]), 64'd1);
        check("drain2_head0", 64'(head_of(2)), 64'd0);
        check("drain2_occ", 64'(occ_of(2)), 64'd0);

        // simultaneous push/pop on full queue 3
        for (int k = 1; k <= 8; k++) push_q(3, PW'(k));
        check("full3", 64'(full[3]), 64'd1);
        produced  = 4'b1000;
        consume   = 4'b1000;
        packetsIn[31:24] = 8'd77;
        step();
        produced = '0;
        consume  = '0;
        check("pp3_occ", 64'(occ_of(3)), 64'd8);
        check("pp3_full", 64'(full[3]), 64'd1);
        check("pp3_ovf", 64'(overflow), 64'h0);
        check("pp3_head", 64'(head_of(3)), 64'd2);
        step();
        check("pp3_ovf_late", 64'(overflow), 64'h0);
        for (int k = 0; k < 7; k++) exp3[k] = PW'(k + 2);
        exp3[7] = 8'd77;
        for (int k = 0; k < 8; k++) begin
            check("drain3_head", 64'(head_of(3)), 64'(exp3[k]));
            pop_q(3);
        end
        check("drain3_empty", 64'(empty[3]), 64'd1);

        // simultaneous push/pop on non-empty queue 0 (holds 42)
        produced = 4'b0001;
        consume  = 4'b0001;
        packetsIn[7:0] = 8'd43;
        step();
        produced = '0;
        consume  = '0;
        check("pp0_occ", 64'(occ_of(0)), 64'd1);
        check("pp0_head", 64'(head_of(0)), 64'd43);

        // pop on empty queue 1 is ignored
        pop_q(1);
        check("pope_empty", 64'(empty), 64'hE);
        check("pope_occ", 64'(occupancy), 64'h0001);
        check("pope_ovf", 64'(overflow), 64'h0);

        // alternating push/pop on queue 1, pointers wrap past depth 8
        for (int j = 0; j < 12; j++) begin
            push_q(1, PW'(100 + j));
            check("alt_occ_push", 64'(occ_of(1)), 64'd1);
            check("alt_head", 64'(head_of(1)), 64'(100 + j));
            pop_q(1);
            check("alt_occ_pop", 64'(occ_of(1)), 64'd0);
        end

        // push+pop on empty queue 1: push accepted, pop ignored
        produced = 4'b0010;
        consume  = 4'b0010;
        packetsIn[15:8] = 8'd55;
        step();
        produced = '0;
        consume  = '0;
        check("ppe_occ", 64'(occ_of(1)), 64'd1);
        check("ppe_head", 64'(head_of(1)), 64'd55);

        // reset with data in flight and active strobes
        reset    = 1'b1;
        produced = '1;
        consume  = '1;
        step();
        reset    = 1'b0;
        produced = '0;
        consume  = '0;
        check("rst2_empty", 64'(empty), 64'hF);
        check("rst2_occ", 64'(occupancy), 64'h0);
        check("rst2_heads", 64'(heads), 64'h0);
        check("rst2_full", 64'(full), 64'h0);

`ifdef QUEUE_BANK_DROP_COUNT_EN
        for (int k = 0; k < 8; k++) push_q(0, PW'(k));
        for (int k = 0; k < 3; k++) push_q(0, 8'hEE);
        check("drop_cnt0", 64'(dropCount[15:0]), 64'd3);
        check("drop_cnt_other", 64'(dropCount[63:16]), 64'h0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("drop_cnt_rst", 64'(dropCount), 64'h0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/queue_bank.md
Name: queue_bank

Overview:
- Per-core packet buffering stage directly downstream of the dispatcher.
- Takes the dispatcher's one-hot `produced` strobes and its per-queue packet lanes, and stores each packet in one of NB_QUEUES independent FIFOs.
- Exposes each queue's head packet, with a per-queue pop handshake, to the EDF scheduler that follows.
- Full queues drop incoming packets and report an overflow pulse.

Parameters:
- PACKET_WIDTH, 8, bits per packet.
- NB_QUEUES, 4, number of queues; matches the dispatcher's lane count.
- QUEUE_DEPTH, 8, entries per queue; must be a power of two and at least 2.

Ports:
- clock  input  1  single system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- packetsIn  input  NB_QUEUES*PACKET_WIDTH  lane i is bits [i*PACKET_WIDTH +: PACKET_WIDTH].
- produced  input  NB_QUEUES  bit i set: push lane i into queue i this cycle.
- consume  input  NB_QUEUES  bit i set: pop the head of queue i this cycle.
- heads  output  NB_QUEUES*PACKET_WIDTH  head packet of each queue (first-word-fall-through).
- empty  output  NB_QUEUES  queue i holds no entries.
- full  output  NB_QUEUES  queue i holds QUEUE_DEPTH entries.
- overflow  output  NB_QUEUES  one-cycle pulse: a push into queue i was dropped.
- occupancy  output  NB_QUEUES*$clog2(QUEUE_DEPTH+1)  entry count per queue.

Behaviour:
- Reset: when reset=1 at a rising edge, for every queue:
  - read/write pointers and occupancy go to 0;
  - empty=1, full=0, overflow=0, heads=0.
  - Reset takes priority over simultaneous produced/consume; in-flight packets are discarded.
- Queues are fully independent; several bits of produced and consume may be set in the same cycle.
- Push: produced[i]=1 and (full[i]=0, or a pop of queue i occurs this cycle):
  - write lane i at the write pointer;
  - write pointer increments modulo QUEUE_DEPTH.
- Pop: consume[i]=1 and empty[i]=0:
  - read pointer increments modulo QUEUE_DEPTH.
  - consume[i] while empty[i]=1 is ignored, with no state change and no error.
- Head outputs: heads lane i is the entry at the read pointer, driven combinationally from storage, and is 0 whenever empty[i]=1.
- Latency: a packet pushed into an empty queue at edge N appears on heads, with empty=0, after edge N.
- Push and pop in the same cycle:
  - non-empty queue: both are performed and occupancy is unchanged;
  - full queue: both are performed, nothing is dropped, full stays 1;
  - empty queue: the pop is ignored and the push is accepted.
- Overflow: produced[i]=1, full[i]=1 and no pop on queue i:
  - packet is dropped and storage is unchanged;
  - overflow[i]=1 for the following cycle only.
- Occupancy is registered and ranges 0..QUEUE_DEPTH.
  - empty = (occupancy==0); full = (occupancy==QUEUE_DEPTH); both decode from registered state.
- Pointers are $clog2(QUEUE_DEPTH) bits and wrap naturally.

Optional Feature:
- Macro: QUEUE_BANK_DROP_COUNT_EN.
- When defined:
  - adds output dropCount, NB_QUEUES*16 bits.
  - One saturating 16-bit counter per queue increments on every dropped push and holds at 0xFFFF.
  - Reset clears it to 0.
- When undefined: no counter logic and no dropCount port; overflow pulses are still generated.

Decomposition:
- Shared package memoredf_pkg holds:
  - PACKET_WIDTH and NB_QUEUES constants;
  - packet_t typedef (logic [PACKET_WIDTH-1:0]);
  - queue_id_t typedef (logic [$clog2(NB_QUEUES)-1:0]).
- One sub-module, packet_fifo: a single FWFT queue with push, pop, head, empty, full, overflow and occupancy.
- queue_bank instantiates NB_QUEUES copies of packet_fifo in a generate loop and handles lane slicing.

Test Plan:
- Reset check: hold reset 1 cycle with produced=4'b1111 -> empty=4'b1111, full=0, heads=0, occupancy=0 on every queue.
- Single push: produced=4'b0001 with lane0=42 for one cycle -> next cycle heads lane0=42, empty[0]=0, occupancy[0]=1; queues 1-3 unchanged.
- Fill and overflow on queue 2:
  - push 8 packets 1..8 -> full[2]=1;
  - a 9th push of 99 -> overflow[2]=1 for exactly one cycle, occupancy stays 8;
  - drain via consume -> 1..8 in order, then empty[2]=1.
- Push and pop on a full queue: queue 3 full with head 1; produced[3]=1 (lane=77) and consume[3]=1 -> occupancy stays 8, no overflow, new head=2, and 77 drains last.
- Pop on empty plus wrap:
  - consume[1] while empty -> no change;
  - then 12 alternating push/pop cycles on queue 1 (pointers wrap) -> FIFO order preserved and occupancy never exceeds 1.
- With QUEUE_BANK_DROP_COUNT_EN: 3 dropped pushes into full queue 0 -> dropCount lane0=3; reset -> 0.
